// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer signal bundle: time/alarm/button inputs from the clock
// core and user controls, ring/snooze status outputs back to the display.
interface alarm_sequencer_if;
  logic       tick_min;
  logic [4:0] cur_hrs;
  logic [5:0] cur_min;
  logic       alarm_en;
  logic [4:0] alarm_hrs;
  logic [5:0] alarm_min;
  logic       snooze;
  logic       dismiss;
  logic       ring;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  logic [2:0] state;

  // Driver side (clock core, buttons, bench)
  modport master (
    output tick_min, cur_hrs, cur_min, alarm_en, alarm_hrs, alarm_min,
           snooze, dismiss,
    input  ring, snoozing, snooze_cnt, state
  );

  // Sequencer side
  modport slave (
    input  tick_min, cur_hrs, cur_min, alarm_en, alarm_hrs, alarm_min,
           snooze, dismiss,
    output ring, snoozing, snooze_cnt, state
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: compares running time to the alarm time, rings, runs
// snooze intervals, caps snoozes per event and auto-silences after a timeout.
module alarm_sequencer #(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE       = 3
) (
  input logic                clk,
  input logic                rst_n,
  alarm_sequencer_if.slave   bus
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_RINGING = 3'd2;
  localparam logic [2:0] ST_SNOOZE  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_MIN);
  localparam logic [5:0] TIMEOUT     = 6'(RING_TIMEOUT_MIN);
  localparam logic [2:0] CNT_MAX     = 3'(MAX_SNOOZE);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;        // snoozes used this event
  logic [5:0] countdown_q, countdown_d;  // minutes left in snooze
  logic [5:0] ring_tmr_q, ring_tmr_d;    // minutes spent ringing
  logic       ring_q, snoozing_q;
  logic       match;
  logic [5:0] ring_tmr_inc;

  assign match        = (bus.cur_hrs == bus.alarm_hrs) && (bus.cur_min == bus.alarm_min);
  assign ring_tmr_inc = ring_tmr_q + 6'd1;

  // Next-state logic; disable overrides everything, then dismiss > snooze > tick/match.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    countdown_d = countdown_q;
    ring_tmr_d  = ring_tmr_q;

    if (!bus.alarm_en) begin
      state_d     = ST_OFF;
      cnt_d       = 3'd0;
      countdown_d = 6'd0;
      ring_tmr_d  = 6'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          // Enabling inside the alarm minute must not ring.
          state_d = match ? ST_DONE : ST_ARMED;
        end
        ST_ARMED: begin
          if (match) begin
            state_d    = ST_RINGING;
            ring_tmr_d = 6'd0;
            cnt_d      = 3'd0;
          end
        end
        ST_RINGING: begin
          if (bus.dismiss) begin
            state_d = ST_DONE;
          end else if (bus.snooze && (cnt_q < CNT_MAX)) begin
            // A tick in the same cycle is dropped in favour of the snooze.
            state_d     = ST_SNOOZE;
            countdown_d = SNOOZE_LOAD;
            cnt_d       = cnt_q + 3'd1;
          end else if (bus.tick_min) begin
            ring_tmr_d = ring_tmr_inc;
            if (ring_tmr_inc == TIMEOUT) state_d = ST_DONE;
          end
        end
        ST_SNOOZE: begin
          if (bus.dismiss) begin
            state_d = ST_DONE;
          end else if (bus.tick_min) begin
            countdown_d = countdown_q - 6'd1;
            if (countdown_q == 6'd1) begin
              state_d    = ST_RINGING;
              ring_tmr_d = 6'd0;
            end
          end
        end
        ST_DONE: begin
          // Hold through the alarm minute; any mismatch re-arms for next time.
          if (!match) state_d = ST_ARMED;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State and timer registers with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= 3'd0;
      countdown_q <= 6'd0;
      ring_tmr_q  <= 6'd0;
      ring_q      <= 1'b0;
      snoozing_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      countdown_q <= countdown_d;
      ring_tmr_q  <= ring_tmr_d;
      ring_q      <= (state_d == ST_RINGING);
      snoozing_q  <= (state_d == ST_SNOOZE);
    end
  end

  assign bus.ring       = ring_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Testbench for alarm_sequencer: table of per-cycle vectors with a scoreboard
// queue of expected outputs, plus a hand-written asynchronous reset sequence.
module tb_alarm_sequencer;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_RING = 3'd2;
  localparam logic [2:0] S_SNZ  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef struct {
    logic       en;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [4:0] ah;
    logic [5:0] am;
    logic       tick;
    logic       snz;
    logic       dis;
    logic [2:0] e_st;
    logic [2:0] e_cnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic       ring;
    logic       snzg;
    logic [2:0] cnt;
    logic [2:0] st;
  } exp_t;

  logic clk;
  logic rst_n;
  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .SNOOZE_MIN      (9),
    .RING_TIMEOUT_MIN(10),
    .MAX_SNOOZE      (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  exp_t sb[$];
  logic [4:0] al_h;
  logic [5:0] al_m;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Append one cycle of stimulus; alarm time comes from al_h/al_m at call time.
  function automatic void row(input logic en, input int hh, input int mm,
                              input logic tick, input logic snz, input logic dis,
                              input logic [2:0] st, input int cnt);
    vec_t v;
    v.en = en; v.hh = 5'(hh); v.mm = 6'(mm); v.ah = al_h; v.am = al_m;
    v.tick = tick; v.snz = snz; v.dis = dis; v.e_st = st; v.e_cnt = 3'(cnt);
    tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    bus.alarm_en  = v.en;
    bus.cur_hrs   = v.hh;
    bus.cur_min   = v.mm;
    bus.alarm_hrs = v.ah;
    bus.alarm_min = v.am;
    bus.tick_min  = v.tick;
    bus.snooze    = v.snz;
    bus.dismiss   = v.dis;
  endtask

  task automatic compare_outputs(input exp_t e);
    check($sformatf("v%0d ring", e.idx),       int'(bus.ring),       int'(e.ring));
    check($sformatf("v%0d snoozing", e.idx),   int'(bus.snoozing),   int'(e.snzg));
    check($sformatf("v%0d snooze_cnt", e.idx), int'(bus.snooze_cnt), int'(e.cnt));
    check($sformatf("v%0d state", e.idx),      int'(bus.state),      int'(e.st));
  endtask

  initial begin
    exp_t e;
    vec_t idle;

    // ---------------- build vector table (alarm 07:30) ----------------
    al_h = 5'd7; al_m = 6'd30;
    // Basic ring
    row(1, 7, 29, 0, 0, 0, S_ARM, 0);
    row(1, 7, 29, 0, 1, 1, S_ARM, 0);            // buttons ignored in ARMED
    row(1, 7, 30, 1, 0, 0, S_RING, 0);           // ring one cycle after match
    row(1, 7, 30, 0, 0, 1, S_DONE, 0);           // dismiss
    row(1, 7, 30, 0, 0, 0, S_DONE, 0);           // still alarm minute
    row(1, 7, 31, 1, 0, 0, S_ARM, 0);            // re-arm
    // Snooze cycle
    row(1, 7, 30, 0, 0, 0, S_RING, 0);
    row(1, 7, 30, 0, 1, 0, S_SNZ, 1);
    for (int i = 0; i < 8; i++) row(1, 8, 0, 1, 0, 0, S_SNZ, 1);
    row(1, 8, 0, 1, 0, 0, S_RING, 1);            // 9th tick rings again
    // Snooze limit
    for (int k = 2; k <= 3; k++) begin
      row(1, 8, 0, 0, 1, 0, S_SNZ, k);
      for (int i = 0; i < 8; i++) row(1, 8, 0, 1, 0, 0, S_SNZ, k);
      row(1, 8, 0, 1, 0, 0, S_RING, k);
    end
    row(1, 8, 0, 0, 1, 0, S_RING, 3);            // 4th snooze ignored
    // Timeout: first tick carries an ignored snooze, tick still counts
    row(1, 8, 0, 1, 1, 0, S_RING, 3);
    for (int i = 0; i < 8; i++) row(1, 8, 0, 1, 0, 0, S_RING, 3);
    row(1, 8, 0, 1, 0, 0, S_DONE, 3);            // 10th tick auto-silences
    row(1, 8, 0, 0, 0, 0, S_ARM, 3);             // count held until next ring
    row(1, 7, 30, 0, 0, 0, S_RING, 0);           // count clears on new event
    row(1, 7, 30, 0, 1, 1, S_DONE, 0);           // dismiss beats snooze
    row(1, 7, 30, 0, 0, 0, S_DONE, 0);
    al_m = 6'd45;
    row(1, 7, 30, 0, 0, 0, S_ARM, 0);            // alarm edit in DONE re-arms
    al_m = 6'd31;
    row(1, 7, 31, 0, 0, 0, S_RING, 0);           // alarm edit in ARMED is immediate
    al_h = 5'd9; al_m = 6'd0;
    row(1, 7, 31, 0, 0, 0, S_RING, 0);           // edit while ringing ignored
    row(1, 8, 0, 1, 1, 0, S_SNZ, 1);             // snooze+tick: tick dropped
    row(1, 8, 0, 1, 1, 0, S_SNZ, 1);             // snooze ignored in SNOOZE
    for (int i = 0; i < 7; i++) row(1, 8, 0, 1, 0, 0, S_SNZ, 1);
    row(1, 8, 0, 1, 0, 0, S_RING, 1);            // full 9 minutes elapsed
    row(1, 8, 0, 0, 0, 1, S_DONE, 1);
    row(1, 8, 0, 0, 0, 0, S_ARM, 1);
    // Enable handling
    al_h = 5'd7; al_m = 6'd30;
    row(0, 7, 30, 0, 0, 0, S_OFF, 0);
    row(0, 7, 30, 1, 1, 1, S_OFF, 0);            // buttons ignored in OFF
    row(1, 7, 30, 0, 0, 0, S_DONE, 0);           // enable during match: no ring
    row(1, 7, 30, 1, 0, 0, S_DONE, 0);
    row(1, 7, 31, 1, 0, 0, S_ARM, 0);
    row(1, 7, 30, 1, 0, 0, S_RING, 0);
    row(1, 7, 30, 0, 1, 0, S_SNZ, 1);
    row(1, 8, 0, 1, 0, 0, S_SNZ, 1);
    row(0, 8, 0, 0, 0, 0, S_OFF, 0);             // disable in SNOOZE clears count
    row(1, 7, 29, 0, 0, 0, S_ARM, 0);
    row(1, 7, 30, 0, 0, 0, S_RING, 0);

    // ---------------- reset ----------------
    idle = '{en: 1'b0, hh: 5'd0, mm: 6'd0, ah: 5'd7, am: 6'd30,
             tick: 1'b0, snz: 1'b0, dis: 1'b0, e_st: S_OFF, e_cnt: 3'd0};
    drive(idle);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e = '{idx: -1, ring: 1'b0, snzg: 1'b0, cnt: 3'd0, st: S_OFF};
    compare_outputs(e);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table-driven run ----------------
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back('{idx: i, ring: (tbl[i].e_st == S_RING),
                     snzg: (tbl[i].e_st == S_SNZ),
                     cnt: tbl[i].e_cnt, st: tbl[i].e_st});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare_outputs(e);
    end

    // ---------------- asynchronous reset while ringing ----------------
    // Table ends in RINGING with alarm_en=1 and time 07:30.
    #2;
    rst_n = 1'b0;
    #1;                                          // well before the next edge
    check("async_rst ring",     int'(bus.ring),       0);
    check("async_rst state",    int'(bus.state),      int'(S_OFF));
    check("async_rst snz_cnt",  int'(bus.snooze_cnt), 0);
    @(posedge clk);
    #1;
    check("rst_held state", int'(bus.state), int'(S_OFF));
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst state", int'(bus.state), int'(S_OFF));
    @(posedge clk);
    #1;
    // Starts from OFF with match present -> DONE, no ring
    check("post_rst done", int'(bus.state), int'(S_DONE));
    check("post_rst ring", int'(bus.ring),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Controls the alarm function of the digital clock. Compares the running 24-hour time from the clock core against a programmed alarm time and drives the ring output. Sequences snooze intervals, limits the number of snoozes and auto-silences after a ring timeout. Sits beside the clock core. Minute timing comes only from the core's one-cycle minute tick; the user buttons feed it directly.

Parameters:
SNOOZE_MIN, 9, snooze interval in minutes (1..63)
RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-silence (1..63)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_min  in  1  one-cycle pulse from clock core at each minute rollover
cur_hrs  in  5  current hour, 24-hour form, 0..23
cur_min  in  6  current minute, 0..59
alarm_en  in  1  alarm enabled (level)
alarm_hrs  in  5  alarm hour, 24-hour form; AM/PM conversion done upstream
alarm_min  in  6  alarm minute
snooze  in  1  one-cycle snooze request
dismiss  in  1  one-cycle dismiss request
ring  out  1  alarm sounding
snoozing  out  1  snooze interval active
snooze_cnt  out  3  snoozes used in current alarm event
state  out  3  FSM state code: OFF=0, ARMED=1, RINGING=2, SNOOZE=3, DONE=4

Behaviour:
- Reset (async, rst_n=0): state=OFF; ring=0; snoozing=0; snooze_cnt=0; internal countdown and ring timer are 0.
- All outputs are registered and change only on the clk rising edge. ring=1 iff state=RINGING. snoozing=1 iff state=SNOOZE.
- "match" means cur_hrs==alarm_hrs and cur_min==alarm_min. It is evaluated combinationally every cycle.
- Priority is evaluated per cycle:
  1. alarm_en=0 from any state -> OFF, clearing snooze_cnt and all timers.
  2. dismiss.
  3. snooze.
  4. tick_min or match.
- OFF: if alarm_en=1 and match -> DONE, so that enabling during the alarm minute does not ring. If alarm_en=1 and no match -> ARMED.
- ARMED: match -> RINGING. On entry, ring timer=0 and snooze_cnt=0. Latency: ring asserts 1 cycle after match first holds.
- RINGING:
  - dismiss -> DONE.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE. Countdown loads SNOOZE_MIN; snooze_cnt increments.
  - snooze with snooze_cnt==MAX_SNOOZE is ignored; the state stays RINGING.
  - tick_min increments the ring timer. When the timer reaches RING_TIMEOUT_MIN, go to DONE (auto-silence).
  - If snooze and tick_min arrive in the same cycle, the snooze is taken and the tick is dropped.
- SNOOZE:
  - dismiss -> DONE.
  - snooze is ignored.
  - tick_min decrements the countdown. The tick that takes it 1->0 moves to RINGING with ring timer=0; snooze_cnt is held.
- DONE: ring=0. Stay in DONE while match. The first cycle with no match -> ARMED. This prevents re-triggering in the same minute and re-arms for the next day.
- Changing alarm_hrs/alarm_min:
  - In ARMED, takes effect immediately.
  - In RINGING or SNOOZE, has no effect on the current event.
  - In DONE, a resulting mismatch re-arms.
- dismiss or snooze in OFF or ARMED: ignored.
- snooze_cnt saturates at MAX_SNOOZE. It clears only on entry to RINGING from ARMED, on alarm_en=0, or on reset.
- Reset asserted mid-operation (any state): outputs drop to reset values asynchronously. After release, the FSM starts in OFF.

Test Plan:
1. Basic ring:
   - Stimulus: reset; alarm_en=1, alarm 07:30, time 07:29; tick_min with time->07:30.
   - Required: state ARMED→RINGING, ring=1 one cycle after match. Dismiss pulse → ring=0, state=DONE. Time→07:31 → state=ARMED.
2. Snooze cycle:
   - Stimulus: RINGING, snooze pulse.
   - Required: snoozing=1, snooze_cnt=1, ring=0. After 8 tick_min, still SNOOZE. On the 9th tick, ring=1.
3. Snooze limit:
   - Stimulus: MAX_SNOOZE=3; snooze 3 times, each followed by 9 ticks.
   - Required: snooze_cnt=3. A fourth snooze leaves ring=1 and state=RINGING.
4. Timeout and priority:
   - Stimulus: RINGING with 10 tick_min and no input → auto-silence. Separately, snooze+dismiss in the same cycle, and snooze+tick_min in the same cycle.
   - Required: 10 ticks → ring=0, state=DONE. Snooze+dismiss → DONE, snooze_cnt unchanged. Snooze+tick_min → SNOOZE, countdown=9.
5. Enable/reset:
   - Stimulus: alarm_en=1 asserted while time==alarm time; alarm_en dropped during SNOOZE; rst_n pulsed low mid-RINGING.
   - Required: enable during match → DONE, no ring. alarm_en=0 in SNOOZE → OFF, snooze_cnt=0. rst_n low → ring=0 immediately (before next clk edge), state=OFF.
